ff_excitation_driver: RTL

//  Drive end of a flip-flop bank: accepts desired next-state words over a valid/ready

---
 rtl/ff_excitation_driver_pkg.sv | 19 +
 rtl/ff_excitation_driver_if.sv | 20 ++
 rtl/ff_excitation_driver_encode.sv | 49 ++++
 rtl/ff_excitation_driver.sv | 107 ++++++++++
 4 files changed

// File: rtl/ff_excitation_driver_pkg.sv
// Shared types for the flip-flop excitation driver.
//   mode_e  : flop family selected for a transaction (D, T, SR, JK)
//   state_e : driver sequencing state (IDLE -> DRIVE -> CHECK)
package ff_exc_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'd0,
    MODE_T  = 2'd1,
    MODE_SR = 2'd2,
    MODE_JK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/ff_excitation_driver_if.sv
// Target-word handshake between a sequence source and the excitation driver.
//   mode      : flop family for the word (sampled on accept)
//   tgt_valid : source offers a target word
//   tgt_ready : driver can take a word
//   tgt_data  : desired flop-bank state after the transaction
interface ff_excitation_driver_if
  import ff_exc_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  mode_e            mode;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (output mode, output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input mode, input tgt_valid, input tgt_data, output tgt_ready);

endinterface

// File: rtl/ff_excitation_driver_encode.sv
// Per-lane excitation table: from present state c, next state n and the flop
// family, produce the D/T/S/R/J/K inputs for one flop lane.
//   c, n   : present / desired state of the lane
//   drive  : high only in the cycle the excitation is to be applied
//   mode   : flop family
//   d..k   : excitation outputs; when not driving (or not selected) every
//            bus holds the flop: d follows c, the others are 0.
// Don't-care entries of the SR/JK tables are resolved to 0, which also
// guarantees s and r are never high together.
module ff_exc_encode
  import ff_exc_pkg::*;
(
  input  logic  c,
  input  logic  n,
  input  logic  drive,
  input  mode_e mode,
  output logic  d,
  output logic  t,
  output logic  s,
  output logic  r,
  output logic  j,
  output logic  k
);

  always_comb begin
    d = c;
    t = 1'b0;
    s = 1'b0;
    r = 1'b0;
    j = 1'b0;
    k = 1'b0;
    if (drive) begin
      case (mode)
        MODE_D:  d = n;
        MODE_T:  t = c ^ n;
        MODE_SR: begin
          s = ~c & n;
          r = c & ~n;
        end
        MODE_JK: begin
          j = ~c & n;
          k = c & ~n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ff_excitation_driver.sv
// Excitation driver for a bank of WIDTH external flops.
// Accepts a target word, drives the excitation for the chosen flop family
// for one cycle, then compares the bank's q feedback against the target and
// keeps a saturating count of failed checks.
//   clk            : rising-edge clock shared with the driven flops
//   reset          : asynchronous, active-low
//   tgt            : target handshake (slave side)
//   d,t,s,r,j,k    : excitation buses, one per flop family
//   q_fb           : actual q of the driven flops
//   chk_en         : enable the comparison in CHECK
//   mismatch       : high during a CHECK cycle whose comparison fails
//   mismatch_lanes : q_fb ^ target from the last enabled check, held
//   err_cnt        : saturating failed-check count
module ff_excitation_driver
  import ff_exc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  ff_excitation_driver_if.slave tgt,
  output logic [WIDTH-1:0]     d,
  output logic [WIDTH-1:0]     t,
  output logic [WIDTH-1:0]     s,
  output logic [WIDTH-1:0]     r,
  output logic [WIDTH-1:0]     j,
  output logic [WIDTH-1:0]     k,
  input  logic [WIDTH-1:0]     q_fb,
  input  logic                 chk_en,
  output logic                 mismatch,
  output logic [WIDTH-1:0]     mismatch_lanes,
  output logic [CNT_W-1:0]     err_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] tgt_q;
  mode_e            mode_q;
  logic [WIDTH-1:0] mirror;
  logic             accept;
  logic             drive_en;
  logic             chk_fail;

  // Ready is gated by reset so nothing can be accepted while reset is held.
  assign tgt.tgt_ready = reset && (state_q == IDLE);
  assign accept        = tgt.tgt_valid && tgt.tgt_ready;
  assign drive_en      = (state_q == DRIVE);
  assign chk_fail      = (state_q == CHECK) && chk_en && (q_fb != tgt_q);
  assign mismatch      = chk_fail;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRIVE;
      DRIVE:   state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      tgt_q          <= '0;
      mode_q         <= MODE_D;
      mirror         <= '0;
      mismatch_lanes <= '0;
      err_cnt        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tgt_q  <= tgt.tgt_data;
        mode_q <= tgt.mode;
      end
      // The flops take the target at the edge closing DRIVE.
      if (state_q == DRIVE) mirror <= tgt_q;
      if (state_q == CHECK) begin
        // Resync to what the hardware really holds, so a failed lane does not
        // skew the excitation of the next transaction.
        mirror <= q_fb;
        if (chk_en) mismatch_lanes <= q_fb ^ tgt_q;
        if (chk_fail) err_cnt <= sat_inc(err_cnt);
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ff_exc_encode u_enc (
      .c     (mirror[i]),
      .n     (tgt_q[i]),
      .drive (drive_en),
      .mode  (mode_q),
      .d     (d[i]),
      .t     (t[i]),
      .s     (s[i]),
      .r     (r[i]),
      .j     (j[i]),
      .k     (k[i])
    );
  end

endmodule
